// File: rtl/seq_stim_ctrl.sv
// Stimulus controller for a sequence detector under test: clears the detector,
// steps it serially through a captured pattern (MSB of the used field first) and counts its matches.
module seq_stim_ctrl #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [4:0]       len,
  input  logic             det_out,
  output logic             det_resetn,
  output logic             det_w,
  output logic             det_step,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic [3:0]       first_hit
);

  localparam int LEN_W = 5;
  localparam int IDX_W = $clog2(PAT_W);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRIVE,
    SAMPLE,
    FINISH
  } state_t;

  state_t             state;
  logic [PAT_W-1:0]   pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   idx;

  logic [LEN_W-1:0]   len_clamped;
  logic [LEN_W-1:0]   first_sel;
  logic [IDX_W-1:0]   next_sel;
  logic               last_bit;

  // Bit-select arithmetic: first_sel addresses the MSB of the used field,
  // next_sel the bit that follows the current idx.
  always_comb begin
    len_clamped = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    first_sel   = len_q - LEN_W'(1);
    next_sel    = IDX_W'(len_q - LEN_W'(2) - LEN_W'(idx));
    last_bit    = (LEN_W'(idx) == first_sel);
  end

  // Outputs are registered alongside the state: each transition loads the
  // output values belonging to the state being entered.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      det_step    <= 1'b0;
      det_w       <= 1'b0;
      det_resetn  <= 1'b0;
      match_count <= '0;
      first_hit   <= '0;
    end else begin
      done       <= 1'b0;
      det_step   <= 1'b0;
      det_w      <= 1'b0;
      det_resetn <= 1'b1;

      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort && len != '0) begin
              state       <= CLEAR;
              busy        <= 1'b1;
              det_resetn  <= 1'b0;
              pattern_q   <= pattern;
              len_q       <= len_clamped;
              idx         <= '0;
              match_count <= '0;
              first_hit   <= '0;
            end
          end

          CLEAR: begin
            state    <= DRIVE;
            det_step <= 1'b1;
            det_w    <= pattern_q[first_sel[IDX_W-1:0]];
          end

          DRIVE: begin
            state <= SAMPLE;
          end

          SAMPLE: begin
            if (det_out) begin
              match_count <= match_count + CNT_W'(1);
              if (match_count == '0) begin
                first_hit <= 4'(idx);
              end
            end
            if (last_bit) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state    <= DRIVE;
              idx      <= idx + IDX_W'(1);
              det_step <= 1'b1;
              det_w    <= pattern_q[next_sel];
            end
          end

          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Directed bench for seq_stim_ctrl with a small step-counting detector model
// whose det_out can be forced low, forced high, or raised at a chosen step count.
module tb_seq_stim_ctrl;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        det_out;
  logic        det_resetn;
  logic        det_w;
  logic        det_step;
  logic        busy;
  logic        done;
  logic [4:0]  match_count;
  logic [3:0]  first_hit;

  int passed = 0;
  int total  = 0;

  // Detector model: counts steps, logs driven bits, counts done pulses.
  logic [1:0]  det_mode;
  logic [4:0]  hit_step;
  logic [4:0]  steps;
  logic [15:0] w_log;
  int          w_cnt;
  int          done_cnt = 0;

  seq_stim_ctrl #(.PAT_W(16), .CNT_W(5)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .abort       (abort),
    .pattern     (pattern),
    .len         (len),
    .det_out     (det_out),
    .det_resetn  (det_resetn),
    .det_w       (det_w),
    .det_step    (det_step),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .first_hit   (first_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign det_out = (det_mode == 2'd1) ? 1'b1 :
                   (det_mode == 2'd2) ? (steps == hit_step) : 1'b0;

  always @(posedge clock) begin
    if (!det_resetn) begin
      steps <= '0;
      w_log <= '0;
      w_cnt <= 0;
    end else if (det_step) begin
      steps <= steps + 5'd1;
      w_log <= {w_log[14:0], det_w};
      w_cnt <= w_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

  // Presents a start request for one edge; returns #1 after the accept edge.
  task automatic start_pass(input logic [15:0] pat, input logic [4:0] l);
    pattern = pat;
    len     = l;
    start   = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
  endtask

  // Waits (bounded) until busy drops. edges = edges waited; done_cyc = cycle
  // number (cycle 1 = the cycle right after the accept edge) in which done was high.
  task automatic wait_pass(output int edges, output int done_cyc);
    edges    = 0;
    done_cyc = -1;
    while (busy === 1'b1 && edges < 100) begin
      @(posedge clock); #1;
      edges++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = edges + 1;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; det_mode = 2'd0; hit_step = '0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (det_resetn !== 1'b0) $display("FAIL reset_det_resetn: got %b want 0", det_resetn); else passed++;
    total++; if (det_step !== 1'b0 || det_w !== 1'b0)
      $display("FAIL reset_det_drive: got step=%b w=%b want 0 0", det_step, det_w); else passed++;
    total++; if (match_count !== 5'd0 || first_hit !== 4'd0)
      $display("FAIL reset_counts: got mc=%0d fh=%0d want 0 0", match_count, first_hit); else passed++;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    total++; if (busy !== 1'b0) $display("FAIL release_busy: got %b want 0", busy); else passed++;
    @(posedge clock); #1;
    total++; if (busy !== 1'b0 || det_resetn !== 1'b1)
      $display("FAIL release_idle: got busy=%b det_resetn=%b want 0 1", busy, det_resetn); else passed++;
  endtask

  task automatic test_basic;
    int e, dc, d0;
    det_mode = 2'd2; hit_step = 5'd4; d0 = done_cnt;
    start_pass(16'h000F, 5'd4);
    total++; if (busy !== 1'b1 || det_resetn !== 1'b0)
      $display("FAIL basic_clear: got busy=%b det_resetn=%b want 1 0", busy, det_resetn); else passed++;
    wait_pass(e, dc);
    total++; if (dc !== 10) $display("FAIL basic_done_cycle: got %0d want 10", dc); else passed++;
    total++; if (e !== 10) $display("FAIL basic_pass_len: got %0d want 10", e); else passed++;
    total++; if (w_cnt !== 4 || w_log[3:0] !== 4'b1111)
      $display("FAIL basic_bits: got cnt=%0d bits=%b want 4 1111", w_cnt, w_log[3:0]); else passed++;
    total++; if (match_count !== 5'd1) $display("FAIL basic_match: got %0d want 1", match_count); else passed++;
    total++; if (first_hit !== 4'd3) $display("FAIL basic_first_hit: got %0d want 3", first_hit); else passed++;
    total++; if (done_cnt - d0 !== 1) $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); else passed++;
  endtask

  task automatic test_order;
    int e, dc;
    det_mode = 2'd0;
    start_pass(16'hFF0B, 5'd4);
    wait_pass(e, dc);
    total++; if (w_log[3:0] !== 4'b1011) $display("FAIL order_bits: got %b want 1011", w_log[3:0]); else passed++;
    total++; if (match_count !== 5'd0) $display("FAIL order_match: got %0d want 0", match_count); else passed++;
    start_pass(16'hFF15, 5'd5);
    wait_pass(e, dc);
    total++; if (w_cnt !== 5 || w_log[4:0] !== 5'b10101)
      $display("FAIL order_len5: got cnt=%0d bits=%b want 5 10101", w_cnt, w_log[4:0]); else passed++;
    total++; if (e !== 12) $display("FAIL order_len5_pass: got %0d want 12", e); else passed++;
  endtask

  task automatic test_zero_len;
    int d0, hi;
    d0 = done_cnt; hi = 0;
    pattern = 16'hFFFF; len = 5'd0; start = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      if (busy !== 1'b0) hi++;
    end
    start = 1'b0;
    @(posedge clock); #1;
    total++; if (hi !== 0) $display("FAIL zero_len_busy: got %0d busy cycles want 0", hi); else passed++;
    total++; if (done_cnt - d0 !== 0) $display("FAIL zero_len_done: got %0d want 0", done_cnt - d0); else passed++;
  endtask

  task automatic test_clamp;
    int e, dc;
    det_mode = 2'd0;
    start_pass(16'hFFFF, 5'd20);
    wait_pass(e, dc);
    total++; if (w_cnt !== 16) $display("FAIL clamp_drives: got %0d want 16", w_cnt); else passed++;
    total++; if (dc !== 34) $display("FAIL clamp_done_cycle: got %0d want 34", dc); else passed++;
    total++; if (w_log !== 16'hFFFF) $display("FAIL clamp_bits_ones: got %h want ffff", w_log); else passed++;
    start_pass(16'hA5C3, 5'd31);
    wait_pass(e, dc);
    total++; if (w_log !== 16'hA5C3) $display("FAIL clamp_bits_order: got %h want a5c3", w_log); else passed++;
  endtask

  task automatic test_count;
    int e, dc;
    det_mode = 2'd1;
    start_pass(16'h0000, 5'd16);
    wait_pass(e, dc);
    total++; if (match_count !== 5'd16) $display("FAIL count_match: got %0d want 16", match_count); else passed++;
    total++; if (first_hit !== 4'd0) $display("FAIL count_first_hit: got %0d want 0", first_hit); else passed++;
    det_mode = 2'd0;
  endtask

  task automatic test_abort;
    int d0;
    det_mode = 2'd2; hit_step = 5'd2; d0 = done_cnt;
    start_pass(16'h00FF, 5'd8);
    repeat (5) @(posedge clock);
    #1;
    total++; if (det_step !== 1'b1) $display("FAIL abort_in_drive: got step=%b want 1", det_step); else passed++;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    total++; if (busy !== 1'b0 || det_step !== 1'b0)
      $display("FAIL abort_idle: got busy=%b step=%b want 0 0", busy, det_step); else passed++;
    repeat (20) @(posedge clock);
    #1;
    total++; if (done_cnt - d0 !== 0) $display("FAIL abort_done: got %0d want 0", done_cnt - d0); else passed++;
    total++; if (match_count !== 5'd1 || first_hit !== 4'd1)
      $display("FAIL abort_partial: got mc=%0d fh=%0d want 1 1", match_count, first_hit); else passed++;
    // abort and start together in IDLE: nothing starts, results held
    pattern = 16'hFFFF; len = 5'd4; start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_start_idle: got busy=%b want 0", busy); else passed++;
    total++; if (match_count !== 5'd1) $display("FAIL idle_hold_match: got %0d want 1", match_count); else passed++;
    det_mode = 2'd0;
  endtask

  task automatic test_back_to_back;
    int e, dc, d0, hi;
    det_mode = 2'd0; d0 = done_cnt; hi = 0;
    start_pass(16'h000B, 5'd4);
    repeat (3) @(posedge clock);
    #1;
    pattern = 16'h0004; len = 5'd3; start = 1'b1;
    repeat (2) @(posedge clock);
    #1 start = 1'b0;
    wait_pass(e, dc);
    total++; if (e + 5 !== 10) $display("FAIL busy_start_len: got %0d want 10", e + 5); else passed++;
    total++; if (w_cnt !== 4 || w_log[3:0] !== 4'b1011)
      $display("FAIL busy_start_bits: got cnt=%0d bits=%b want 4 1011", w_cnt, w_log[3:0]); else passed++;
    repeat (12) begin
      @(posedge clock); #1;
      if (busy !== 1'b0) hi++;
    end
    total++; if (hi !== 0) $display("FAIL busy_start_queued: got %0d busy cycles want 0", hi); else passed++;
    total++; if (done_cnt - d0 !== 1) $display("FAIL busy_start_done: got %0d want 1", done_cnt - d0); else passed++;
  endtask

  task automatic test_async_reset;
    int e, dc, d0;
    det_mode = 2'd2; hit_step = 5'd2;
    start_pass(16'h003C, 5'd6);
    repeat (6) @(posedge clock);
    #1;
    total++; if (busy !== 1'b1 || match_count !== 5'd1 || first_hit !== 4'd1)
      $display("FAIL pre_reset_state: got busy=%b mc=%0d fh=%0d want 1 1 1", busy, match_count, first_hit); else passed++;
    d0 = done_cnt;
    #3 resetn = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || det_resetn !== 1'b0)
      $display("FAIL async_ctrl: got busy=%b done=%b det_resetn=%b want 0 0 0", busy, done, det_resetn); else passed++;
    total++; if (det_step !== 1'b0 || det_w !== 1'b0 || match_count !== 5'd0 || first_hit !== 4'd0)
      $display("FAIL async_data: got step=%b w=%b mc=%0d fh=%0d want 0 0 0 0",
               det_step, det_w, match_count, first_hit); else passed++;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    total++; if (busy !== 1'b0 || det_resetn !== 1'b1 || done_cnt !== d0)
      $display("FAIL post_reset_idle: got busy=%b det_resetn=%b done_pulses=%0d want 0 1 0",
               busy, det_resetn, done_cnt - d0); else passed++;
    hit_step = 5'd4;
    start_pass(16'h000F, 5'd4);
    wait_pass(e, dc);
    total++; if (dc !== 10 || match_count !== 5'd1 || first_hit !== 4'd3)
      $display("FAIL restart_pass: got dc=%0d mc=%0d fh=%0d want 10 1 3", dc, match_count, first_hit); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_zero_len();
    test_clamp();
    test_count();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
